// File: rtl/ascon_round_ctrl.sv
// Round sequencer for the ASCON permutation: steps the round index through
// p12 (0..11) or p6 (6..11) and drives the datapath enable, mux select and round constant.
module ascon_round_ctrl (
  input  logic       clock_i,
  input  logic       resetb_i,
  input  logic       start_i,
  input  logic       mode_i,
  input  logic       abort_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       en_state_o,
  output logic       sel_init_o,
  output logic [3:0] round_idx_o,
  output logic [7:0] round_const_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [3:0] LAST_IDX = 4'd11;

  state_t     r_state;
  logic [3:0] r_idx;
  logic       r_busy;
  logic       r_done;
  logic       r_en;
  logic       r_sel;
  logic [7:0] r_const;

  state_t     w_nstate;
  logic [3:0] w_nidx;
  logic       w_nfirst;
  logic [3:0] w_start_idx;

  assign w_start_idx = mode_i ? 4'd6 : 4'd0;

  always_comb begin
    w_nstate = S_IDLE;
    w_nidx   = '0;
    w_nfirst = 1'b0;
    if (!abort_i) begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            w_nstate = S_RUN;
            w_nidx   = w_start_idx;
            w_nfirst = 1'b1;
          end
        end
        S_RUN: begin
          // >= rather than == so a corrupted index still terminates the run
          if (r_idx >= LAST_IDX) begin
            w_nstate = S_DONE;
          end else begin
            w_nstate = S_RUN;
            w_nidx   = r_idx + 4'd1;
          end
        end
        default: begin
          w_nstate = S_IDLE;
        end
      endcase
    end
  end

  // Outputs are registered from the next-state values so they are pure Moore
  // outputs of the state/index registers with no input-to-output path.
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_en    <= 1'b0;
      r_sel   <= 1'b0;
      r_const <= '0;
    end else begin
      r_state <= w_nstate;
      r_idx   <= w_nidx;
      r_busy  <= (w_nstate == S_RUN);
      r_en    <= (w_nstate == S_RUN);
      r_done  <= (w_nstate == S_DONE);
      r_sel   <= w_nfirst;
      r_const <= (w_nstate == S_RUN) ? {4'hF - w_nidx, w_nidx} : '0;
    end
  end

  assign busy_o        = r_busy;
  assign done_o        = r_done;
  assign en_state_o    = r_en;
  assign sel_init_o    = r_sel;
  assign round_idx_o   = r_idx;
  assign round_const_o = r_const;

endmodule

// File: tb/tb_ascon_round_ctrl.sv
// Self-checking bench for ascon_round_ctrl: a p12 vector table, directed
// back-to-back/abort/reset sequences and random traffic against a cycle model.
module tb_ascon_round_ctrl;

  logic       clk = 1'b0;
  logic       rstn;
  logic       start, mode, abort;
  logic       busy, done, en, sel;
  logic [3:0] idx;
  logic [7:0] cnst;

  ascon_round_ctrl dut (
    .clock_i      (clk),
    .resetb_i     (rstn),
    .start_i      (start),
    .mode_i       (mode),
    .abort_i      (abort),
    .busy_o       (busy),
    .done_o       (done),
    .en_state_o   (en),
    .sel_init_o   (sel),
    .round_idx_o  (idx),
    .round_const_o(cnst)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       en;
    logic       sel;
    logic [3:0] idx;
    logic [7:0] cnst;
  } out_t;

  typedef struct {
    logic s;
    logic m;
    logic a;
    out_t exp;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  out_t sb[$];

  // Reference model state: 0 idle, 1 run, 2 done
  int   m_st;
  int   m_idx;
  bit   m_first;
  bit   prev_done;

  function automatic out_t mk(logic b, logic d, logic s, logic [3:0] i, logic [7:0] c);
    out_t o;
    o.busy = b; o.done = d; o.en = b; o.sel = s; o.idx = i; o.cnst = c;
    return o;
  endfunction

  function automatic out_t act();
    return mk(busy, done, sel, idx, cnst) | out_t'({2'b00, en ^ busy, 13'd0});
  endfunction

  function automatic out_t model_out();
    logic [3:0] i4;
    logic [3:0] hi;
    i4 = 4'(m_idx);
    hi = 4'(15 - m_idx);
    return mk(m_st == 1, m_st == 2, m_first && m_st == 1, i4,
              (m_st == 1) ? {hi, i4} : 8'h00);
  endfunction

  function automatic void model_reset();
    m_st = 0; m_idx = 0; m_first = 0;
  endfunction

  function automatic void model_step(logic s, logic m, logic a);
    if (a) begin
      m_st = 0; m_idx = 0; m_first = 0;
    end else if (m_st == 1) begin
      m_first = 0;
      if (m_idx == 11) begin m_st = 2; m_idx = 0; end
      else m_idx = m_idx + 1;
    end else if (s) begin
      m_st = 1; m_idx = m ? 6 : 0; m_first = 1;
    end else begin
      m_st = 0;
    end
  endfunction

  task automatic check(input string name, input out_t got, input out_t want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got busy=%b done=%b en=%b sel=%b idx=%0d const=%h exp busy=%b done=%b en=%b sel=%b idx=%0d const=%h",
               name, got.busy, got.done, got.en, got.sel, got.idx, got.cnst,
               want.busy, want.done, want.en, want.sel, want.idx, want.cnst);
    end
  endtask

  // One clock: drive inputs, push the expected post-edge outputs, compare after the edge
  task automatic cyc(input logic s, input logic m, input logic a, input string name,
                     input logic use_t = 1'b0, input out_t texp = '0);
    out_t want;
    out_t got;
    start = s; mode = m; abort = a;
    model_step(s, m, a);
    sb.push_back(use_t ? texp : model_out());
    @(posedge clk);
    #1;
    got = act();
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s scoreboard empty", name);
    end else begin
      want = sb.pop_front();
      check(name, got, want);
    end
    if (prev_done && done) begin
      checks++; errors++;
      $display("FAIL %s done high two cycles got=1 exp=0", name);
    end
    prev_done = done;
  endtask

  vec_t       tbl[14];
  logic [7:0] p12c[12];

  initial begin
    p12c = '{8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5,
             8'h96, 8'h87, 8'h78, 8'h69, 8'h5A, 8'h4B};
    for (int i = 0; i < 12; i++)
      tbl[i] = '{s: (i == 0), m: 1'b0, a: 1'b0, exp: mk(1'b1, 1'b0, i == 0, 4'(i), p12c[i])};
    tbl[12] = '{s: 1'b0, m: 1'b0, a: 1'b0, exp: mk(1'b0, 1'b1, 1'b0, 4'd0, 8'h00)};
    tbl[13] = '{s: 1'b0, m: 1'b0, a: 1'b0, exp: mk(1'b0, 1'b0, 1'b0, 4'd0, 8'h00)};

    prev_done = 0;
    model_reset();
    rstn = 1'b0; start = 0; mode = 0; abort = 0;
    #3;
    check("reset_state", act(), '0);
    @(posedge clk); #2;
    rstn = 1'b1;
    cyc(0, 0, 0, "idle_after_reset");
    cyc(0, 0, 0, "idle_hold");

    for (int i = 0; i < 14; i++)
      cyc(tbl[i].s, tbl[i].m, tbl[i].a, $sformatf("p12_row%0d", i), 1'b1, tbl[i].exp);

    cyc(1, 1, 0, "p6_start");
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, $sformatf("p6_run%0d", i));
    cyc(0, 0, 0, "p6_done");
    cyc(0, 0, 0, "p6_idle");

    // Back-to-back with a mid-run start pulse that must be ignored
    cyc(1, 0, 0, "b2b_start");
    for (int i = 1; i < 12; i++) cyc(i == 5, 1, 0, $sformatf("b2b_run%0d", i));
    cyc(0, 0, 0, "b2b_done");
    cyc(1, 1, 0, "b2b_restart");
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, $sformatf("b2b_p6_%0d", i));
    cyc(0, 0, 0, "b2b_done2");
    cyc(0, 0, 0, "b2b_idle");

    cyc(1, 0, 0, "abort_start");
    for (int i = 1; i <= 4; i++) cyc(0, 0, 0, $sformatf("abort_run%0d", i));
    cyc(0, 0, 1, "abort_hit");
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, $sformatf("abort_nodone%0d", i));
    cyc(1, 0, 1, "abort_beats_start");
    cyc(0, 0, 0, "abort_idle");

    for (int n = 0; n < 400; n++) begin
      cyc($urandom_range(0, 99) < 25, $urandom_range(0, 1) == 1,
          $urandom_range(0, 99) < 4, "random");
      checks++;
      if (cnst !== (busy ? {~idx, idx} : 8'h00)) begin
        errors++;
        $display("FAIL const_inv got=%h exp=%h", cnst, busy ? {~idx, idx} : 8'h00);
      end
      checks++;
      if (en !== busy) begin
        errors++;
        $display("FAIL en_eq_busy got=%b exp=%b", en, busy);
      end
    end
    cyc(0, 0, 1, "random_flush");

    // Asynchronous reset in the middle of a run
    cyc(1, 0, 0, "rst_start");
    cyc(0, 0, 0, "rst_run1");
    cyc(0, 0, 0, "rst_run2");
    #2;
    rstn = 1'b0;
    #1;
    check("reset_async", act(), '0);
    model_reset();
    prev_done = 0;
    @(posedge clk); #2;
    check("reset_held", act(), '0);
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, $sformatf("reset_idle%0d", i));
    cyc(1, 1, 0, "reset_restart");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
